// File: rtl/regfile_sb_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package rf_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0]   reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xlen_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/issue bundle between the core controller and the register file.
interface regfile_sb_if
    import rf_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS
) ();

    localparam int AW = $clog2(NREGS);

    logic [AW-1:0]    A1;
    logic [AW-1:0]    A2;
    logic [XLEN-1:0]  RD1;
    logic [XLEN-1:0]  RD2;
    logic [AW-1:0]    A3;
    logic [XLEN-1:0]  WD3;
    logic             WE3;
    logic             IssueEn;
    logic [AW-1:0]    IssueRd;
    logic             Busy1;
    logic             Busy2;
    logic             Hazard;
    logic [NREGS-1:0] BusyVec;

    modport master (
        output A1, A2, A3, WD3, WE3, IssueEn, IssueRd,
        input  RD1, RD2, Busy1, Busy2, Hazard, BusyVec
    );

    modport slave (
        input  A1, A2, A3, WD3, WE3, IssueEn, IssueRd,
        output RD1, RD2, Busy1, Busy2, Hazard, BusyVec
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: one set/clear flop per register plus the
// RAW/WAW hazard decode the controller stalls on.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = DEF_NREGS,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    a1,
    input  logic [AW-1:0]    a2,
    input  logic [AW-1:0]    a3,
    input  logic             wr,       // effective write (zero-reg already masked)
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_rd,
    output logic             busy1,
    output logic             busy2,
    output logic             hazard,
    output logic [NREGS-1:0] busy_vec
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [NREGS-1:0] busy;
    logic             iss;
    logic             waw;

    assign iss = issue_en & ~(ZR & (issue_rd == '0));

    // Per-register flags; a new issue wins over a completing write because
    // the new producer supersedes the one finishing now.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst)
                busy[i] <= 1'b0;
            else if (iss && issue_rd == AW'(i))
                busy[i] <= 1'b1;
            else if (wr && a3 == AW'(i))
                busy[i] <= 1'b0;
        end
    end

    // A register completing this cycle counts as resolved only when its data
    // is forwarded; WAW ignores forwarding since the write lands this edge.
    always_comb begin
        busy1  = busy[a1] & ~(BYP & wr & (a3 == a1));
        busy2  = busy[a2] & ~(BYP & wr & (a3 == a2));
        waw    = iss & busy[issue_rd] & ~(wr & (a3 == issue_rd));
        hazard = busy1 | busy2 | waw;
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port, optional write-to-read forwarding, and a busy
// scoreboard for overlapping long-latency operations.
module regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    localparam int AW  = $clog2(NREGS);
    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [XLEN-1:0]           regs [NREGS];
    logic                      wr;
    logic [1:0][AW-1:0]        ra;
    logic [1:0][XLEN-1:0]      rd;

    // Writes to a hardwired zero register are dropped everywhere, including
    // the scoreboard clear and the forwarding path.
    assign wr = bus.WE3 & ~(ZR & (bus.A3 == '0));

    // Data array; reset clears every entry and beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wr) begin
            regs[bus.A3] <= bus.WD3;
        end
    end

    assign ra = {bus.A2, bus.A1};

    for (genvar p = 0; p < 2; p++) begin : g_rd
        // Read mux: zero register first, then forwarded write, then array.
        always_comb begin
            rd[p] = regs[ra[p]];
            if (BYP && wr && bus.A3 == ra[p])
                rd[p] = bus.WD3;
            if (ZR && ra[p] == '0)
                rd[p] = '0;
        end
    end

    assign bus.RD1 = rd[0];
    assign bus.RD2 = rd[1];

    rf_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .a1       (bus.A1),
        .a2       (bus.A2),
        .a3       (bus.A3),
        .wr       (wr),
        .issue_en (bus.IssueEn),
        .issue_rd (bus.IssueRd),
        .busy1    (bus.Busy1),
        .busy2    (bus.Busy2),
        .hazard   (bus.Hazard),
        .busy_vec (bus.BusyVec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (forwarding + zero reg, and plain
// array with ordinary r0) driven by the same stimulus and compared against
// a behavioural model of the register/scoreboard rules.
module tb_regfile_sb;
    import rf_pkg::*;

    localparam int XL = 32;
    localparam int NR = 32;
    localparam int AW = $clog2(NR);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] a1, a2, a3, ird;
    logic [XL-1:0] wd3;
    logic          we3, ien;

    int checks = 0;
    int errors = 0;

    regfile_sb_if #(.XLEN(XL), .NREGS(NR)) bus_a ();
    regfile_sb_if #(.XLEN(XL), .NREGS(NR)) bus_b ();

    assign bus_a.A1 = a1;   assign bus_b.A1 = a1;
    assign bus_a.A2 = a2;   assign bus_b.A2 = a2;
    assign bus_a.A3 = a3;   assign bus_b.A3 = a3;
    assign bus_a.WD3 = wd3; assign bus_b.WD3 = wd3;
    assign bus_a.WE3 = we3; assign bus_b.WE3 = we3;
    assign bus_a.IssueEn = ien; assign bus_b.IssueEn = ien;
    assign bus_a.IssueRd = ird; assign bus_b.IssueRd = ird;

    regfile_sb #(.XLEN(XL), .NREGS(NR), .BYPASS(1), .ZERO_REG(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    regfile_sb #(.XLEN(XL), .NREGS(NR), .BYPASS(0), .ZERO_REG(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Reference state, index 0 = dut_a config, 1 = dut_b config.
    logic [XL-1:0] m_regs [2][NR];
    bit            m_busy [2][NR];
    bit            byp [2] = '{1'b1, 1'b0};
    bit            zr  [2] = '{1'b1, 1'b0};

    function automatic bit e_wr(int c);
        return we3 && !(zr[c] && a3 == 0);
    endfunction

    function automatic bit e_iss(int c);
        return ien && !(zr[c] && ird == 0);
    endfunction

    function automatic logic [XL-1:0] e_rd(int c, logic [AW-1:0] a);
        if (zr[c] && a == 0) return '0;
        if (byp[c] && e_wr(c) && a3 == a) return wd3;
        return m_regs[c][a];
    endfunction

    function automatic bit e_bsy(int c, logic [AW-1:0] a);
        return m_busy[c][a] && !(byp[c] && e_wr(c) && a3 == a);
    endfunction

    function automatic bit e_haz(int c);
        bit waw;
        waw = e_iss(c) && m_busy[c][ird] && !(e_wr(c) && a3 == ird);
        return e_bsy(c, a1) || e_bsy(c, a2) || waw;
    endfunction

    function automatic logic [NR-1:0] e_vec(int c);
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[c][i];
        return v;
    endfunction

    task automatic chk(string tag, logic [XL-1:0] obs, logic [XL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("%s/c%0d/RD1", tag, c), c == 0 ? bus_a.RD1 : bus_b.RD1, e_rd(c, a1));
            chk($sformatf("%s/c%0d/RD2", tag, c), c == 0 ? bus_a.RD2 : bus_b.RD2, e_rd(c, a2));
            chk($sformatf("%s/c%0d/Busy1", tag, c), {31'd0, c == 0 ? bus_a.Busy1 : bus_b.Busy1},
                {31'd0, e_bsy(c, a1)});
            chk($sformatf("%s/c%0d/Busy2", tag, c), {31'd0, c == 0 ? bus_a.Busy2 : bus_b.Busy2},
                {31'd0, e_bsy(c, a2)});
            chk($sformatf("%s/c%0d/Hazard", tag, c), {31'd0, c == 0 ? bus_a.Hazard : bus_b.Hazard},
                {31'd0, e_haz(c)});
            chk($sformatf("%s/c%0d/BusyVec", tag, c), c == 0 ? bus_a.BusyVec : bus_b.BusyVec, e_vec(c));
        end
    endtask

    // Advance one clock and apply the specification's state rules to the model.
    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < NR; i++) begin
                    m_regs[c][i] = '0;
                    m_busy[c][i] = 1'b0;
                end
            end else begin
                if (e_wr(c)) m_regs[c][a3] = wd3;
                for (int i = 0; i < NR; i++) begin
                    if (e_iss(c) && ird == i) m_busy[c][i] = 1'b1;
                    else if (e_wr(c) && a3 == i) m_busy[c][i] = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic step(string tag);
        #1;
        check_all(tag);
        tick();
    endtask

    initial begin
        a1 = '0; a2 = '0; a3 = '0; ird = '0; wd3 = '0; we3 = 0; ien = 0;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < NR; i++) begin
                m_regs[c][i] = '0;
                m_busy[c][i] = 1'b0;
            end

        // 1: reset with a write pending, then read back zeros
        rst = 1; we3 = 1; a3 = 5; wd3 = 32'hDEAD;
        tick();
        rst = 0; we3 = 0; a1 = 5; a2 = 0;
        #1;
        chk("t1_rd1_a", bus_a.RD1, 32'h0);
        chk("t1_rd1_b", bus_b.RD1, 32'h0);
        chk("t1_vec_a", bus_a.BusyVec, 32'h0);
        step("t1");

        // 2: write and forwarding
        we3 = 1; a3 = 7; wd3 = 32'h1234_5678; a1 = 7;
        #1;
        chk("t2_byp_a", bus_a.RD1, 32'h1234_5678);
        chk("t2_nobyp_b", bus_b.RD1, 32'h0);
        step("t2a");
        we3 = 0;
        #1;
        chk("t2_late_b", bus_b.RD1, 32'h1234_5678);
        step("t2b");

        // 3: zero register write and issue
        we3 = 1; a3 = 0; wd3 = 32'hFFFF_FFFF; ien = 1; ird = 0; a1 = 0;
        #1;
        chk("t3_rd1_a", bus_a.RD1, 32'h0);
        chk("t3_haz_a", {31'd0, bus_a.Hazard}, 32'h0);
        step("t3a");
        we3 = 0; ien = 0;
        #1;
        chk("t3_rd1_b", bus_b.RD1, 32'hFFFF_FFFF);
        chk("t3_vec0_b", {31'd0, bus_b.BusyVec[0]}, 32'h1);
        chk("t3_vec0_a", {31'd0, bus_a.BusyVec[0]}, 32'h0);
        step("t3b");

        // 4: RAW stall and resolution
        a1 = 1; ien = 1; ird = 9;
        step("t4a");
        ien = 0; a2 = 9;
        #1;
        chk("t4_busy2_a", {31'd0, bus_a.Busy2}, 32'h1);
        chk("t4_haz_a", {31'd0, bus_a.Hazard}, 32'h1);
        step("t4b");
        we3 = 1; a3 = 9; wd3 = 32'h42;
        #1;
        chk("t4_busy2_res_a", {31'd0, bus_a.Busy2}, 32'h0);
        chk("t4_rd2_a", bus_a.RD2, 32'h42);
        chk("t4_busy2_b", {31'd0, bus_b.Busy2}, 32'h1);
        step("t4c");
        we3 = 0;
        #1;
        chk("t4_vec9_a", {31'd0, bus_a.BusyVec[9]}, 32'h0);
        step("t4d");

        // 5: issue and write to the same register in one cycle
        ien = 1; ird = 3;
        step("t5a");
        we3 = 1; a3 = 3; wd3 = 32'h77; a1 = 10; a2 = 11;
        #1;
        chk("t5_haz_a", {31'd0, bus_a.Hazard}, 32'h0);
        step("t5b");
        we3 = 0; ien = 0; a1 = 3;
        #1;
        chk("t5_vec3_a", {31'd0, bus_a.BusyVec[3]}, 32'h1);
        chk("t5_rd1_b", bus_b.RD1, 32'h77);
        step("t5c");

        // 6: WAW then reset in the middle of a pending write
        ien = 1; ird = 4; a1 = 12; a2 = 12;
        step("t6a");
        #1;
        chk("t6_waw_a", {31'd0, bus_a.Hazard}, 32'h1);
        step("t6b");
        rst = 1; ird = 6;
        step("t6c");
        rst = 0; ien = 0;
        #1;
        chk("t6_vec_a", bus_a.BusyVec, 32'h0);
        chk("t6_vec_b", bus_b.BusyVec, 32'h0);
        step("t6d");

        // Randomised traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            a1  = AW'($urandom_range(0, 7));
            a2  = AW'($urandom_range(0, 7));
            a3  = AW'($urandom_range(0, 7));
            ird = AW'($urandom_range(0, 7));
            wd3 = $urandom;
            we3 = $urandom_range(0, 1) == 1;
            ien = $urandom_range(0, 2) == 0;
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
